ab_bcd_sweep_ctrl: RTL and testbench
====================================

// Module: ab_bcd_sweep_ctrl
// PURPOSE
//  Sequencer that sweeps all 16 input combinations {A,B,C,D} through the
//  external combinational function unit Q = A&B | B&C&D. It waits a settle
//  time per vector, then captures Q into a 16-bit truth table and counts the
//  ones. It compares the table bit-by-bit against an expected table and
//  reports the first mismatching vector. It sits between the lab test
//  harness (start/done) and the function unit (f_abcd/f_q).
// PARAMETERS
//  SETTLE   1   cycles each vector is held before f_q is sampled (>=1)
// PORTS
//  clk         in   1   single clock; all state changes on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  start       in   1   begin sweep; honoured only in IDLE
//  abort       in   1   cancel sweep; honoured only while busy
//  expected    in   16  expected truth table, bit i = Q for vector i; latched on start
//  f_abcd      out  4   vector to function unit: {A,B,C,D} = idx[3:0], A = MSB
//  f_q         in   1   function unit output Q
//  busy        out  1   high from accepted start until DONE/abort
//  done        out  1   one-cycle pulse when sweep completes
//  truth_table out  16  captured Q values, bit i = vector i
//  ones_count  out  5   number of 1s captured (0..16)
//  mismatch    out  1   at least one captured bit != expected bit
//  first_bad   out  4   lowest vector index with a mismatch (valid if mismatch)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, f_abcd=0, busy=0, done=0,
//    truth_table=0, ones_count=0, mismatch=0, first_bad=0, idx=0, wait cnt=0.
//  - FSM states: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
//  - IDLE: on start=1 at edge k, latch expected and clear the results. Set
//    idx=0, cnt=0, busy=1, go to SETTLE. start in other states is ignored.
//  - SETTLE: f_abcd=idx held. cnt increments each cycle. When cnt==SETTLE-1,
//    go to SAMPLE. f_q is never sampled in SETTLE.
//  - SAMPLE (1 cycle, f_abcd still = idx):
//    - truth_table[idx]<=f_q; ones_count+=f_q.
//    - If f_q!=exp[idx] and mismatch==0: mismatch<=1, first_bad<=idx.
//    - If idx==15, go to DONE. Else idx++, cnt=0, go to SETTLE.
//  - Each vector takes SETTLE+1 cycles. Last sample is at edge k+16*(SETTLE+1).
//    At that edge: busy<=0, done<=1, state=DONE.
//  - DONE: done stays high for exactly one cycle, then state returns to IDLE
//    and done<=0. start can be accepted in the IDLE cycle that follows.
//  - Results (truth_table, ones_count, mismatch, first_bad) hold until the
//    next accepted start or reset.
//  - abort=1 while busy (SETTLE/SAMPLE): next edge goes to IDLE with busy=0
//    and f_abcd=0. done is not pulsed. Results hold partial values and are
//    not valid. abort wins over a same-cycle SAMPLE capture.
//  - abort and start together in IDLE: start wins (abort is ignored when not busy).
//  - ones_count is 5 bits; 16 ones = 5'd16, no wrap. idx is 4 bits and
//    never wraps mid-sweep (15 terminates).
//  - Reset mid-sweep: immediate return to the reset values; no done pulse.
// TESTING
//  1 Assert rst_n=0 then release -> all outputs 0, busy=0,
//    f_abcd=4'h0 until start.
//  2 SETTLE=1; bench models Q=A&B|B&C&D; start with expected=16'hF080 ->
//    done pulses 1 cycle, 32 cycles after start. truth_table=16'hF080,
//    ones_count=5, mismatch=0.
//  3 Same run with expected=16'hF0C0 -> truth_table=16'hF080, mismatch=1,
//    first_bad=4'd6.
//  4 Pulse start at cycle 5 of a sweep -> ignored, done still at cycle 32.
//    abort at cycle 10 -> busy=0 next cycle, f_abcd=0, no done.
//  5 Drive rst_n=0 at cycle 20 of a sweep -> outputs reset asynchronously.
//    Then start again -> full clean sweep, truth_table=16'hF080.
//  6 SETTLE=3; bench forces f_q=~Q during settle cycles -> truth_table
//    =16'hF080 (sampled only in SAMPLE), done 64 cycles after start.

Source files
------------

// File: rtl/ab_bcd_sweep_ctrl.sv
// ab_bcd_sweep_ctrl
//   Walks the 16 input vectors {A,B,C,D} through an external combinational
//   function unit, holds each vector for SETTLE cycles, and then samples the
//   unit's output for one cycle. It builds a truth table and a ones count, and
//   compares the table against an expected table that is latched at start.
//
// Ports
//   clk, rst_n    clock, async active-low reset
//   start         begin a sweep (accepted only when idle)
//   abort         cancel a running sweep (ignored when not busy)
//   expected[15:0] expected truth table, latched when start is accepted
//   f_abcd[3:0]   vector to the function unit, A = MSB
//   f_q           function unit output
//   busy          high from the accepted start until the sweep ends or aborts
//   done          one-cycle pulse when a sweep completes
//   truth_table   captured Q values, bit i = vector i
//   ones_count    number of ones captured (0..16)
//   mismatch      at least one captured bit differed from expected
//   first_bad     lowest mismatching vector index
module ab_bcd_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic [3:0]  f_abcd,
  input  logic        f_q,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_count,
  output logic        mismatch,
  output logic [3:0]  first_bad
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_exp;
  logic            r_busy, r_done, r_mis;
  logic [15:0]     r_tt;
  logic [4:0]      r_ones;
  logic [3:0]      r_bad;

  logic            w_accept, w_abort, w_capture, w_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: begin
        if (abort)                 w_next = S_IDLE;
        else if (r_cnt == CNT_LAST) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)              w_next = S_IDLE;
        else if (r_idx == 4'hF) w_next = S_DONE;
        else                    w_next = S_SETTLE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state. Abort suppresses the
  // capture so a cancelled sweep never records the in-flight sample.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && start;
    w_abort   = abort && ((r_state == S_SETTLE) || (r_state == S_SAMPLE));
    w_capture = (r_state == S_SAMPLE) && !abort;
    w_last    = w_capture && (r_idx == 4'hF);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_exp  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_tt   <= '0;
      r_ones <= '0;
      r_mis  <= 1'b0;
      r_bad  <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_exp  <= expected;
        r_tt   <= '0;
        r_ones <= '0;
        r_mis  <= 1'b0;
        r_bad  <= '0;
        r_idx  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (w_abort) begin
        r_busy <= 1'b0;
        r_idx  <= '0;
        r_cnt  <= '0;
      end else if (r_state == S_SETTLE) begin
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end else if (w_capture) begin
        r_tt[r_idx] <= f_q;
        r_ones      <= r_ones + 5'(f_q);
        if ((f_q != r_exp[r_idx]) && !r_mis) begin
          r_mis <= 1'b1;
          r_bad <= r_idx;
        end
        r_cnt <= '0;
        if (w_last) begin
          // Return the vector bus to 0 once the sweep finishes.
          r_busy <= 1'b0;
          r_idx  <= '0;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

  assign f_abcd      = r_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign truth_table = r_tt;
  assign ones_count  = r_ones;
  assign mismatch    = r_mis;
  assign first_bad   = r_bad;

endmodule

// File: tb/tb_ab_bcd_sweep_ctrl.sv
// Directed bench for ab_bcd_sweep_ctrl: one instance with SETTLE=1 and one
// with SETTLE=3, each driven by a model of Q = A&B | B&C&D.
module tb_ab_bcd_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic        start1 = 0, abort1 = 0, force1 = 0;
  logic [15:0] exp1 = '0;
  logic [3:0]  fa1, bad1;
  logic        fq1, busy1, done1, mis1;
  logic [15:0] tt1;
  logic [4:0]  ones1;

  // SETTLE=3 instance
  logic        start3 = 0, abort3 = 0, corrupt = 0;
  logic [15:0] exp3 = '0;
  logic [3:0]  fa3, bad3;
  logic        fq3, busy3, done3, mis3;
  logic [15:0] tt3;
  logic [4:0]  ones3;

  int n_chk = 0;
  int n_err = 0;

  function automatic logic q_of(input logic [3:0] v);
    return (v[3] & v[2]) | (v[2] & v[1] & v[0]);
  endfunction

  assign fq1 = force1 ? 1'b1 : q_of(fa1);
  assign fq3 = corrupt ? ~q_of(fa3) : q_of(fa3);

  ab_bcd_sweep_ctrl #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1),
    .f_abcd(fa1), .f_q(fq1), .busy(busy1), .done(done1), .truth_table(tt1),
    .ones_count(ones1), .mismatch(mis1), .first_bad(bad1));

  ab_bcd_sweep_ctrl #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .expected(exp3),
    .f_abcd(fa3), .f_q(fq3), .busy(busy3), .done(done3), .truth_table(tt3),
    .ones_count(ones3), .mismatch(mis3), .first_bad(bad3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue start to u1, then count edges until done shows (bounded).
  task automatic sweep1(input logic [15:0] e, input int bound, output int lat);
    @(negedge clk); start1 = 1; exp1 = e;
    @(negedge clk); start1 = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done1 && lat < bound);
  endtask

  initial begin
    int lat;
    logic seen;

    // 1: reset values
    #1;
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_fabcd", 32'(fa1), 0);
    chk("rst_tt", 32'(tt1), 0);
    chk("rst_ones_mis_bad", {ones1, mis1, bad1}, 0);
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
    chk("idle_fabcd", 32'(fa1), 0);
    chk("idle_busy", 32'(busy1), 0);

    // 2: clean sweep, matching expected
    sweep1(16'hF080, 100, lat);
    chk("t2_latency", lat, 32);
    chk("t2_tt", 32'(tt1), 32'h0000F080);
    chk("t2_ones", 32'(ones1), 5);
    chk("t2_mis", 32'(mis1), 0);
    chk("t2_busy_end", 32'(busy1), 0);
    @(negedge clk);
    chk("t2_done_1cyc", 32'(done1), 0);

    // 3: expected differs at vector 6
    sweep1(16'hF0C0, 100, lat);
    chk("t3_latency", lat, 32);
    chk("t3_tt", 32'(tt1), 32'h0000F080);
    chk("t3_mis", 32'(mis1), 1);
    chk("t3_bad", 32'(bad1), 6);

    // 4a: start pulsed mid-sweep is ignored
    @(negedge clk); start1 = 1; exp1 = 16'hF080;
    @(negedge clk); start1 = 0;
    chk("t4_busy", 32'(busy1), 1);
    repeat (5) @(negedge clk);
    chk("t4_fabcd_c5", 32'(fa1), 2);
    start1 = 1; exp1 = 16'h0000;
    @(negedge clk); start1 = 0;
    lat = 6;
    do begin @(negedge clk); lat++; end while (!done1 && lat < 100);
    chk("t4_latency", lat, 32);
    chk("t4_mis", 32'(mis1), 0);

    // 4b: abort at cycle 10
    @(negedge clk); start1 = 1; exp1 = 16'hF080;
    @(negedge clk); start1 = 0;
    repeat (9) @(negedge clk);
    abort1 = 1;
    @(negedge clk); abort1 = 0;
    chk("t4_abort_busy", 32'(busy1), 0);
    chk("t4_abort_fabcd", 32'(fa1), 0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done1) seen = 1; end
    chk("t4_abort_nodone", 32'(seen), 0);
    chk("t4_abort_fabcd_hold", 32'(fa1), 0);

    // 5: async reset mid-sweep, then clean sweep
    @(negedge clk); start1 = 1; exp1 = 16'hF080;
    @(negedge clk); start1 = 0;
    repeat (20) @(negedge clk);
    chk("t5_partial_tt", 32'(tt1), 32'h00000080);
    #2 rst_n = 0;
    #1;
    chk("t5_rst_busy", 32'(busy1), 0);
    chk("t5_rst_fabcd", 32'(fa1), 0);
    chk("t5_rst_tt", 32'(tt1), 0);
    chk("t5_rst_ones", 32'(ones1), 0);
    @(negedge clk); rst_n = 1;
    sweep1(16'hF080, 100, lat);
    chk("t5_latency", lat, 32);
    chk("t5_tt", 32'(tt1), 32'h0000F080);
    chk("t5_ones", 32'(ones1), 5);

    // All ones: ones_count reaches 16 without wrapping
    force1 = 1;
    sweep1(16'hFFFF, 100, lat);
    force1 = 0;
    chk("ones16_cnt", 32'(ones1), 16);
    chk("ones16_tt", 32'(tt1), 32'h0000FFFF);
    chk("ones16_mis", 32'(mis1), 0);

    // 6: SETTLE=3, f_q corrupted everywhere except the sample cycle
    @(negedge clk); start3 = 1; exp3 = 16'hF080;
    @(negedge clk); start3 = 0;
    seen = 0;
    for (int j = 0; j < 64; j++) begin
      corrupt = ((j % 4) != 3);
      @(negedge clk);
      if (j < 63 && done3) seen = 1;
    end
    chk("t6_done_at64", 32'(done3), 1);
    chk("t6_no_early_done", 32'(seen), 0);
    corrupt = 0;
    chk("t6_tt", 32'(tt3), 32'h0000F080);
    chk("t6_ones", 32'(ones3), 5);
    chk("t6_mis", 32'(mis3), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
